// File: rtl/imuldiv_mul_front.sv
// Front-end/writeback stage around the iterative multiplier: tracks {fn, tag} in order, selects the result word.
// Optional feature: IMULDIV_MUL_FRONT_ZERO_SHORTCUT_EN answers zero-operand requests without the multiplier.
module imuldiv_mul_front #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      req_msg_a,
   input  logic [31:0]      req_msg_b,
   input  logic             req_msg_fn,
   input  logic [TAG_W-1:0] req_msg_tag,
   input  logic             req_val,
   output logic             req_rdy,
   output logic [31:0]      mulreq_msg_a,
   output logic [31:0]      mulreq_msg_b,
   output logic             mulreq_val,
   input  logic             mulreq_rdy,
   input  logic [63:0]      mulresp_msg_result,
   input  logic             mulresp_val,
   output logic             mulresp_rdy,
   output logic [31:0]      resp_msg_result,
   output logic [TAG_W-1:0] resp_msg_tag,
   output logic             resp_val,
   input  logic             resp_rdy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             r_fn  [DEPTH];
   logic [TAG_W-1:0] r_tag [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             r_resp_val;
   logic [31:0]      r_resp_result;
   logic [TAG_W-1:0] r_resp_tag;

   logic w_full;
   logic w_empty;
   logic w_out_free;
   logic w_zero_req;
   logic w_req_go;
   logic w_push;
   logic w_pop;

   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_out_free = ~r_resp_val | resp_rdy;

`ifdef IMULDIV_MUL_FRONT_ZERO_SHORTCUT_EN
   // Only safe with nothing outstanding, so the shortcut result cannot overtake a product.
   assign w_zero_req = ((req_msg_a == '0) || (req_msg_b == '0)) && w_empty && w_out_free;
`else
   assign w_zero_req = 1'b0;
`endif

   assign mulreq_msg_a = req_msg_a;
   assign mulreq_msg_b = req_msg_b;
   assign mulreq_val   = req_val & ~w_full & ~w_zero_req;
   assign req_rdy      = w_zero_req | (mulreq_rdy & ~w_full);
   assign w_req_go     = req_val & req_rdy;
   assign w_push       = w_req_go & ~w_zero_req;

   assign mulresp_rdy  = ~w_empty & w_out_free;
   assign w_pop        = mulresp_val & mulresp_rdy;

   assign resp_val        = r_resp_val;
   assign resp_msg_result = r_resp_result;
   assign resp_msg_tag    = r_resp_tag;

   // NOTE: tracking storage has no reset; pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fn[r_wr_ptr]  <= req_msg_fn;
         r_tag[r_wr_ptr] <= req_msg_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_resp_val    <= 1'b0;
         r_resp_result <= '0;
         r_resp_tag    <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);

         if (w_pop) begin
            r_resp_val    <= 1'b1;
            r_resp_result <= r_fn[r_rd_ptr] ? mulresp_msg_result[63:32] : mulresp_msg_result[31:0];
            r_resp_tag    <= r_tag[r_rd_ptr];
         end else if (w_req_go && w_zero_req) begin
            r_resp_val    <= 1'b1;
            r_resp_result <= '0;
            r_resp_tag    <= req_msg_tag;
         end else if (r_resp_val && resp_rdy) begin
            r_resp_val    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imuldiv_mul_front.sv
// Self-checking bench for imuldiv_mul_front: directed cases plus random traffic against a queue-based reference.
module tb_imuldiv_mul_front;

   localparam int TAG_W = 4;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      req_msg_a, req_msg_b;
   logic             req_msg_fn;
   logic [TAG_W-1:0] req_msg_tag;
   logic             req_val, req_rdy;
   logic [31:0]      mulreq_msg_a, mulreq_msg_b;
   logic             mulreq_val, mulreq_rdy;
   logic [63:0]      mulresp_msg_result;
   logic             mulresp_val, mulresp_rdy;
   logic [31:0]      resp_msg_result;
   logic [TAG_W-1:0] resp_msg_tag;
   logic             resp_val, resp_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0]      prod;
      logic             fn;
      logic [TAG_W-1:0] tag;
   } txn_t;

   txn_t             q[$];          // accepted by the multiplier, response not yet consumed
   bit               m_val;         // model of the output register
   logic [31:0]      m_word;
   logic [TAG_W-1:0] m_tag;

   imuldiv_mul_front #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .req_msg_a          (req_msg_a),
      .req_msg_b          (req_msg_b),
      .req_msg_fn         (req_msg_fn),
      .req_msg_tag        (req_msg_tag),
      .req_val            (req_val),
      .req_rdy            (req_rdy),
      .mulreq_msg_a       (mulreq_msg_a),
      .mulreq_msg_b       (mulreq_msg_b),
      .mulreq_val         (mulreq_val),
      .mulreq_rdy         (mulreq_rdy),
      .mulresp_msg_result (mulresp_msg_result),
      .mulresp_val        (mulresp_val),
      .mulresp_rdy        (mulresp_rdy),
      .resp_msg_result    (resp_msg_result),
      .resp_msg_tag       (resp_msg_tag),
      .resp_val           (resp_val),
      .resp_rdy           (resp_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   function automatic logic [31:0] pick(input logic [63:0] prod, input logic fn);
      return fn ? prod[63:32] : prod[31:0];
   endfunction

   task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic fn, input logic [TAG_W-1:0] tag);
      req_val = v; req_msg_a = a; req_msg_b = b; req_msg_fn = fn; req_msg_tag = tag;
   endtask

   task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic fn, input logic [TAG_W-1:0] tag,
                         input logic [63:0] prod, input logic [31:0] exp_res);
      tick();
      drive_req(1'b1, a, b, fn, tag);
      settle();
      check({name, " req_rdy"}, req_rdy, 1);
      check({name, " mulreq_val"}, mulreq_val, 1);
      check({name, " mulreq_a"}, mulreq_msg_a, a);
      check({name, " mulreq_b"}, mulreq_msg_b, b);
      tick();
      req_val = 1'b0;
      mulresp_val = 1'b1;
      mulresp_msg_result = prod;
      settle();
      check({name, " mulresp_rdy"}, mulresp_rdy, 1);
      check({name, " resp_val early"}, resp_val, 0);
      tick();
      mulresp_val = 1'b0;
      settle();
      check({name, " resp_val"}, resp_val, 1);
      check({name, " result"}, resp_msg_result, exp_res);
      check({name, " tag"}, resp_msg_tag, tag);
      tick();
      settle();
      check({name, " drained"}, resp_val, 0);
   endtask

   // One random cycle: drive, compare against the model, then advance the model.
   task automatic rand_cycle(input bit drain);
      bit req_go, mresp_go, out_go;
      txn_t t;
      tick();
      if (drain) begin
         drive_req(1'b0, $urandom, $urandom, 1'($urandom), TAG_W'($urandom));
         resp_rdy = 1'b1;
         mulreq_rdy = 1'b1;
      end else begin
         drive_req($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), TAG_W'($urandom));
         case ($urandom_range(0, 7))
            0: req_msg_a = 32'h0;
            1: req_msg_a = 32'h8000_0000;
            2: req_msg_a = 32'hFFFF_FFFF;
            default: ;
         endcase
         case ($urandom_range(0, 7))
            0: req_msg_b = 32'h0;
            1: req_msg_b = 32'h7FFF_FFFF;
            2: req_msg_b = 32'hFFFF_FFFF;
            default: ;
         endcase
         mulreq_rdy = ($urandom_range(0, 3) != 0);
         resp_rdy   = ($urandom_range(0, 2) != 0);
      end
      if (q.size() > 0) begin
         mulresp_val = drain ? 1'b1 : 1'($urandom);
         mulresp_msg_result = q[0].prod;
      end else begin
         mulresp_val = 1'b0;
         mulresp_msg_result = {$urandom, $urandom};
      end
      settle();

      check("rnd req_rdy", req_rdy, mulreq_rdy && (q.size() < DEPTH));
      check("rnd mulreq_val", mulreq_val, req_val && (q.size() < DEPTH));
      check("rnd mulreq_a", mulreq_msg_a, req_msg_a);
      check("rnd mulresp_rdy", mulresp_rdy, (q.size() > 0) && (!m_val || resp_rdy));
      check("rnd resp_val", resp_val, m_val);
      if (m_val) begin
         check("rnd result", resp_msg_result, m_word);
         check("rnd tag", resp_msg_tag, m_tag);
      end

      req_go   = req_val && mulreq_rdy && (q.size() < DEPTH);
      mresp_go = mulresp_val && (q.size() > 0) && (!m_val || resp_rdy);
      out_go   = m_val && resp_rdy;
      if (mresp_go) begin
         t = q.pop_front();
         m_val  = 1'b1;
         m_word = pick(t.prod, t.fn);
         m_tag  = t.tag;
      end else if (out_go) begin
         m_val = 1'b0;
      end
      if (req_go) begin
         t.prod = smul(req_msg_a, req_msg_b);
         t.fn   = req_msg_fn;
         t.tag  = req_msg_tag;
         q.push_back(t);
      end
   endtask

   initial begin
      int budget;
      reset = 1'b0;
      drive_req(1'b1, 32'd7, 32'd9, 1'b0, 4'd3);
      mulreq_rdy = 1'b1;
      mulresp_val = 1'b0;
      mulresp_msg_result = '0;
      resp_rdy = 1'b1;

      // Reset held for two edges with a request pending.
      tick();
      tick();
      reset = 1'b1;
      settle();
      check("reset resp_val", resp_val, 0);
      check("reset mulresp_rdy", mulresp_rdy, 0);
      check("reset result", resp_msg_result, 0);
      check("reset tag", resp_msg_tag, 0);
      req_val = 1'b0;

      // Consume the request that may have been accepted on the first post-reset edge.
      tick();
      settle();
      if (mulresp_rdy) begin
         mulresp_val = 1'b1;
         tick();
         mulresp_val = 1'b0;
         tick();
      end

      do_mul("mul_lo", 32'd3, 32'hFFFF_FFFB, 1'b0, 4'd5, 64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFF1);
      do_mul("mulh", 32'h8000_0000, 32'd2, 1'b1, 4'd9, 64'hFFFF_FFFF_0000_0000, 32'hFFFF_FFFF);

      // Full tracking FIFO: third request must wait for the first response.
      tick();
      drive_req(1'b1, 32'd1, 32'd11, 1'b0, 4'd1);
      settle();
      check("full req1 rdy", req_rdy, 1);
      tick();
      drive_req(1'b1, 32'd2, 32'd11, 1'b0, 4'd2);
      settle();
      check("full req2 rdy", req_rdy, 1);
      tick();
      drive_req(1'b1, 32'd3, 32'd11, 1'b0, 4'd3);
      settle();
      check("full req3 rdy", req_rdy, 0);
      check("full req3 mulreq_val", mulreq_val, 0);
      tick();
      mulresp_val = 1'b1;
      mulresp_msg_result = 64'd11;
      settle();
      check("full no bypass", req_rdy, 0);
      check("full pop rdy", mulresp_rdy, 1);
      tick();
      mulresp_val = 1'b0;
      settle();
      check("full out1 tag", resp_msg_tag, 1);
      check("full out1 result", resp_msg_result, 11);
      check("full req3 rdy after pop", req_rdy, 1);
      tick();
      req_val = 1'b0;
      mulresp_val = 1'b1;
      mulresp_msg_result = 64'd22;
      tick();
      mulresp_msg_result = 64'd33;
      settle();
      check("full out2 tag", resp_msg_tag, 2);
      check("full refill rdy", mulresp_rdy, 1);
      tick();
      mulresp_val = 1'b0;
      settle();
      check("full out3 val", resp_val, 1);
      check("full out3 tag", resp_msg_tag, 3);
      check("full out3 result", resp_msg_result, 33);
      tick();
      settle();
      check("full drained", resp_val, 0);

      // Backpressure on the output register.
      resp_rdy = 1'b0;
      tick();
      drive_req(1'b1, 32'd4, 32'd1, 1'b0, 4'd4);
      tick();
      drive_req(1'b1, 32'd6, 32'd1, 1'b1, 4'd6);
      tick();
      req_val = 1'b0;
      mulresp_val = 1'b1;
      mulresp_msg_result = 64'h0000_0000_0000_0004;
      tick();
      mulresp_msg_result = 64'h0000_0066_0000_0006;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("bp mulresp_rdy", mulresp_rdy, 0);
         check("bp resp_val", resp_val, 1);
         check("bp result", resp_msg_result, 4);
         check("bp tag", resp_msg_tag, 4);
         tick();
      end
      resp_rdy = 1'b1;
      settle();
      check("bp release rdy", mulresp_rdy, 1);
      tick();
      mulresp_val = 1'b0;
      settle();
      check("bp refill val", resp_val, 1);
      check("bp refill tag", resp_msg_tag, 6);
      check("bp refill result", resp_msg_result, 32'h66);
      tick();
      settle();
      check("bp drained", resp_val, 0);

      // Reset with one multiply outstanding.
      drive_req(1'b1, 32'd5, 32'd5, 1'b0, 4'd7);
      tick();
      req_val = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mulresp_val = 1'b1;
      mulresp_msg_result = 64'd25;
      settle();
      check("midrst resp_val", resp_val, 0);
      check("midrst mulresp_rdy", mulresp_rdy, 0);
      check("midrst req_rdy", req_rdy, 1);
      tick();
      settle();
      check("midrst ignored", resp_val, 0);
      mulresp_val = 1'b0;

      // Random traffic against the queue model, then a bounded drain.
      q.delete();
      m_val = 1'b0;
      m_word = '0;
      m_tag = '0;
      for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
      budget = 0;
      while ((q.size() > 0 || m_val) && budget < 50) begin
         rand_cycle(1'b1);
         budget++;
      end
      check("drain bounded", (q.size() > 0 || m_val), 0);
      tick();
      mulresp_val = 1'b0;
      settle();
      check("final resp_val", resp_val, 0);
      check("final mulresp_rdy", mulresp_rdy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
